irq_injector: RTL and testbench
===============================

IRQ_INJECTOR -- requirements
Module: irq_injector

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, number of independent interrupt channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, width of the monitored PC.
REQ-003 SHALL have parameter CNT_W, default 8, width of the delay and pulse counters.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pc  input  ADDR_W  CPU fetch address under observation.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-008 SHALL have port cfg_ch  input  3  target channel index; writes with cfg_ch >= NUM_CH are ignored.
REQ-009 SHALL have port cfg_field  input  2  0=match address, 1=delay, 2=pulse length, 3=control.
REQ-010 SHALL have port cfg_wdata  input  32  write data, LSB-aligned, truncated to field width.
REQ-011 SHALL have port irq_ack  input  NUM_CH  per-channel acknowledge from the CPU.
REQ-012 SHALL have port irq  output  NUM_CH  registered interrupt lines.
REQ-013 SHALL have port spent  output  NUM_CH  high while the channel is in SPENT.
REQ-014 SHALL have port busy  output  1  OR over channels in DELAY or ASSERT.

Function
REQ-015 SHALL give each channel the registers match[ADDR_W], delay[CNT_W], pulse[CNT_W] and ctrl = {sticky(bit2), rearm(bit1), enable(bit0)}.
REQ-016 SHALL run one FSM per channel with states IDLE, DELAY, ASSERT, SPENT.
REQ-017 SHALL define trigger = enable & (pc==match) & ~hit_q, where hit_q is (pc==match) registered, so that only an entry into the match address fires.
REQ-018 SHALL move IDLE->ASSERT on trigger when delay==0, else IDLE->DELAY with count loaded to delay.
REQ-019 SHALL decrement count in DELAY each cycle and move DELAY->ASSERT in the cycle count==1.
REQ-020 SHALL make irq rise exactly delay+1 cycles after the edge sampling the trigger.
REQ-021 SHALL hold irq high in ASSERT for max(pulse,1) cycles when sticky=0.
REQ-022 SHALL hold irq high in ASSERT until irq_ack when sticky=1, ignoring pulse.
REQ-023 SHALL end ASSERT early when irq_ack is high in either mode; irq falls on the next edge.
REQ-024 SHALL leave ASSERT to IDLE when rearm=1, else to SPENT.
REQ-025 SHALL leave SPENT only on a control write with enable=1, which goes to IDLE.
REQ-026 SHALL, on a control write with enable=0, force the channel to IDLE and drive irq low on the next edge, from any state.
REQ-027 SHALL apply writes to match, delay and pulse without disturbing an operation in flight; new values take effect at the next trigger.
REQ-028 SHALL give a control write precedence over a same-cycle trigger or ack on that channel.
REQ-029 SHALL have no ordering or arbitration between channels; simultaneous triggers assert simultaneously.
REQ-030 SHALL ignore irq_ack on a channel not in ASSERT.

Reset
REQ-031 SHALL, while reset is high, clear all match, delay, pulse, ctrl and hit_q registers and place every FSM in IDLE.
REQ-032 SHALL drive irq=0, spent=0 and busy=0 during reset and in the first cycle after it.
REQ-033 SHALL abort any DELAY or ASSERT on reset mid-operation, with no pending state surviving.

Verification
REQ-034 SHALL cover: ch0 match=0x3018, delay=0, pulse=5, ctrl=1; pc=0x3018 sampled at edge k -> irq[0] high edges k+1..k+5, then spent[0]=1.
REQ-035 SHALL cover: ch1 delay=3, pulse=2, ctrl=3 (rearm); pc held at match for 10 cycles -> exactly one 2-cycle pulse starting at k+4; pc leaves and returns -> second pulse.
REQ-036 SHALL cover: ch2 ctrl=5 (sticky), pulse=1; irq_ack asserted 7 cycles after irq rises -> irq high 7 cycles, falls the edge after ack, then SPENT.
REQ-037 SHALL cover: ch0 and ch3 sharing match=0x3000, both enabled -> both irq rise on the same edge; busy=1 throughout.
REQ-038 SHALL cover: reset asserted asynchronously mid-DELAY -> irq=0 and busy=0 immediately; channel stays disabled after release.
REQ-039 SHALL cover: a control write with enable=0 during ASSERT while irq_ack is also high -> irq low the next edge, state IDLE, spent=0.

Source files
------------

// File: rtl/irq_injector.sv
// PC-match interrupt injector: each channel raises a delayed irq pulse (or a
// sticky level held until ack) when the fetch address enters its match value.
//
// state  | meaning
// IDLE   | armed when enabled, waiting for pc to enter match
// DELAY  | counting down the delay latched at trigger
// ASSERT | irq high until pulse expires (sticky=0) or ack
// SPENT  | fired without rearm; only a control write with enable=1 leaves
module irq_injector #(
    parameter int NUM_CH = 6,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [1:0]        cfg_field,
    input  logic [31:0]       cfg_wdata,
    input  logic [NUM_CH-1:0] irq_ack,
    output logic [NUM_CH-1:0] irq,
    output logic [NUM_CH-1:0] spent,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ASSERT = 2'd2,
        SPENT  = 2'd3
    } state_e;

    localparam logic [1:0]       FLD_MATCH = 2'd0;
    localparam logic [1:0]       FLD_DELAY = 2'd1;
    localparam logic [1:0]       FLD_PULSE = 2'd2;
    localparam logic [1:0]       FLD_CTRL  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e            state_q     [NUM_CH];
    state_e            state_d     [NUM_CH];
    logic [ADDR_W-1:0] match_q     [NUM_CH];
    logic [ADDR_W-1:0] match_d     [NUM_CH];
    logic [CNT_W-1:0]  delay_q     [NUM_CH];
    logic [CNT_W-1:0]  delay_d     [NUM_CH];
    logic [CNT_W-1:0]  pulse_q     [NUM_CH];
    logic [CNT_W-1:0]  pulse_d     [NUM_CH];
    logic [CNT_W-1:0]  pulse_lat_q [NUM_CH];
    logic [CNT_W-1:0]  pulse_lat_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q       [NUM_CH];
    logic [CNT_W-1:0]  cnt_d       [NUM_CH];
    logic [2:0]        ctrl_q      [NUM_CH];
    logic [2:0]        ctrl_d      [NUM_CH];

    logic [NUM_CH-1:0] hit_q;
    logic [NUM_CH-1:0] hit_d;
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] irq_d;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] trig;
    logic [NUM_CH-1:0] ack_eff;

    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    // A zero pulse length still gives a one-cycle pulse.
    function automatic logic [CNT_W-1:0] pulse_len(input logic [CNT_W-1:0] p);
        return (p == '0) ? CNT_ONE : p;
    endfunction

    // Per-channel decode; a control write masks a same-cycle trigger and ack.
    always_comb begin
        sel     = '0;
        ctrl_wr = '0;
        trig    = '0;
        ack_eff = '0;
        hit_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]     = cfg_we && (cfg_ch == 3'(i));
            ctrl_wr[i] = sel[i] && (cfg_field == FLD_CTRL);
            hit_d[i]   = (pc == match_q[i]);
            trig[i]    = ctrl_q[i][0] && hit_d[i] && !hit_q[i] && !ctrl_wr[i];
            ack_eff[i] = irq_ack[i] && !ctrl_wr[i];
        end
    end

    always_comb begin
        irq_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]     = state_q[i];
            cnt_d[i]       = cnt_q[i];
            pulse_lat_d[i] = pulse_lat_q[i];
            match_d[i]     = match_q[i];
            delay_d[i]     = delay_q[i];
            pulse_d[i]     = pulse_q[i];
            ctrl_d[i]      = ctrl_q[i];

            case (state_q[i])
                IDLE: begin
                    if (trig[i]) begin
                        pulse_lat_d[i] = pulse_q[i];
                        if (delay_q[i] == '0) begin
                            state_d[i] = ASSERT;
                            cnt_d[i]   = pulse_len(pulse_q[i]);
                        end else begin
                            state_d[i] = DELAY;
                            cnt_d[i]   = delay_q[i];
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q[i] == CNT_ONE) begin
                        state_d[i] = ASSERT;
                        cnt_d[i]   = pulse_len(pulse_lat_q[i]);
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                ASSERT: begin
                    irq_d[i] = !ack_eff[i];
                    if (ack_eff[i] || (!ctrl_q[i][2] && cnt_q[i] == CNT_ONE)) begin
                        state_d[i] = ctrl_q[i][1] ? IDLE : SPENT;
                    end else if (!ctrl_q[i][2]) begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
                SPENT: begin
                    state_d[i] = SPENT;
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase

            if (ctrl_wr[i]) begin
                ctrl_d[i] = cfg_wdata[2:0];
                if (!cfg_wdata[0]) begin
                    state_d[i] = IDLE;
                    irq_d[i]   = 1'b0;
                end else if (state_q[i] == SPENT) begin
                    state_d[i] = IDLE;
                end
            end

            // Field writes only touch the programmed values, never the op in flight.
            if (sel[i] && cfg_field == FLD_MATCH) match_d[i] = ADDR_W'(cfg_wdata);
            if (sel[i] && cfg_field == FLD_DELAY) delay_d[i] = CNT_W'(cfg_wdata);
            if (sel[i] && cfg_field == FLD_PULSE) pulse_d[i] = CNT_W'(cfg_wdata);
        end
    end

    always_comb begin
        spent = '0;
        busy  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            spent[i] = (state_q[i] == SPENT);
            busy     = busy | (state_q[i] == DELAY) | (state_q[i] == ASSERT);
        end
    end

    assign irq = irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q <= '0;
            irq_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]     <= IDLE;
                match_q[i]     <= '0;
                delay_q[i]     <= '0;
                pulse_q[i]     <= '0;
                pulse_lat_q[i] <= '0;
                cnt_q[i]       <= '0;
                ctrl_q[i]      <= '0;
            end
        end else begin
            hit_q <= hit_d;
            irq_q <= irq_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]     <= state_d[i];
                match_q[i]     <= match_d[i];
                delay_q[i]     <= delay_d[i];
                pulse_q[i]     <= pulse_d[i];
                pulse_lat_q[i] <= pulse_lat_d[i];
                cnt_q[i]       <= cnt_d[i];
                ctrl_q[i]      <= ctrl_d[i];
            end
        end
    end

endmodule

// File: tb/tb_irq_injector.sv
// Bench for irq_injector: directed scenarios plus random traffic, all checked
// against a timestamp-based channel model.
module tb_irq_injector;
    localparam int NUM_CH = 6;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;
    localparam logic [31:0] PC_IDLE = 32'h0000_4000;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [1:0]        cfg_field;
    logic [31:0]       cfg_wdata;
    logic [NUM_CH-1:0] irq_ack;
    logic [NUM_CH-1:0] irq;
    logic [NUM_CH-1:0] spent;
    logic              busy;

    irq_injector #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pc(pc), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .irq_ack(irq_ack),
        .irq(irq), .spent(spent), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: an op is remembered by its trigger edge t, latched delay d and length p.
    logic [31:0]      m_match  [NUM_CH];
    logic [CNT_W-1:0] m_delay  [NUM_CH];
    logic [CNT_W-1:0] m_pulse  [NUM_CH];
    logic [2:0]       m_ctrl   [NUM_CH];
    bit               m_hit    [NUM_CH];
    bit               m_active [NUM_CH];
    bit               m_spent  [NUM_CH];
    int               m_t      [NUM_CH];
    int               m_d      [NUM_CH];
    int               m_p      [NUM_CH];
    logic [NUM_CH-1:0] e_irq;
    int cyc = 0;

    task automatic model_reset();
        e_irq = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_match[ch] = '0; m_delay[ch] = '0; m_pulse[ch] = '0; m_ctrl[ch] = '0;
            m_hit[ch] = 1'b0; m_active[ch] = 1'b0; m_spent[ch] = 1'b0;
            m_t[ch] = 0; m_d[ch] = 0; m_p[ch] = 0;
        end
    endtask

    task automatic model_edge();
        cyc++;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit sel, cw, eq, ack, was_active, was_spent;
            sel        = cfg_we && (int'(cfg_ch) == ch);
            cw         = sel && (cfg_field == 2'd3);
            eq         = (pc == m_match[ch]);
            ack        = irq_ack[ch] && !cw;
            was_active = m_active[ch];
            was_spent  = m_spent[ch];
            e_irq[ch]  = 1'b0;
            if (was_active && cyc >= m_t[ch] + m_d[ch] + 1) begin
                if (ack) begin
                    m_active[ch] = 1'b0;
                    m_spent[ch]  = !m_ctrl[ch][1];
                end else begin
                    e_irq[ch] = 1'b1;
                    if (!m_ctrl[ch][2] && cyc == m_t[ch] + m_d[ch] + m_p[ch]) begin
                        m_active[ch] = 1'b0;
                        m_spent[ch]  = !m_ctrl[ch][1];
                    end
                end
            end
            if (!was_active && !was_spent && !cw && m_ctrl[ch][0] && eq && !m_hit[ch]) begin
                m_active[ch] = 1'b1;
                m_t[ch] = cyc;
                m_d[ch] = int'(m_delay[ch]);
                m_p[ch] = (m_pulse[ch] == '0) ? 1 : int'(m_pulse[ch]);
            end
            if (cw) begin
                if (!cfg_wdata[0]) begin
                    m_active[ch] = 1'b0;
                    m_spent[ch]  = 1'b0;
                    e_irq[ch]    = 1'b0;
                end else if (was_spent) begin
                    m_spent[ch] = 1'b0;
                end
                m_ctrl[ch] = cfg_wdata[2:0];
            end
            m_hit[ch] = eq;
            if (sel && cfg_field == 2'd0) m_match[ch] = cfg_wdata;
            if (sel && cfg_field == 2'd1) m_delay[ch] = cfg_wdata[CNT_W-1:0];
            if (sel && cfg_field == 2'd2) m_pulse[ch] = cfg_wdata[CNT_W-1:0];
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] e_spent;
        logic e_busy;
        e_spent = '0;
        e_busy  = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            e_spent[ch] = m_spent[ch];
            e_busy      = e_busy | m_active[ch];
        end
        chk({tag, ".irq"},   32'(irq),   32'(e_irq));
        chk({tag, ".spent"}, 32'(spent), 32'(e_spent));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic cfg_write(input int ch, input int field, input logic [31:0] data);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_field = 2'(field); cfg_wdata = data;
        step("cfg");
        cfg_we = 1'b0;
    endtask

    task automatic cfg_chan(input int ch, input logic [31:0] m, input int d, input int p, input int c);
        cfg_write(ch, 0, m);
        cfg_write(ch, 1, 32'(d));
        cfg_write(ch, 2, 32'(p));
        cfg_write(ch, 3, 32'(c));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.irq",   32'(irq),   32'd0);
        chk("rst.spent", 32'(spent), 32'd0);
        chk("rst.busy",  32'(busy),  32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n_hi, first, r;
        reset = 1'b1; pc = PC_IDLE; cfg_we = 1'b0; cfg_ch = '0; cfg_field = '0;
        cfg_wdata = '0; irq_ack = '0;
        do_reset();
        step("post_rst");

        // Single pulse, delay 0, then SPENT.
        cfg_chan(0, 32'h3018, 0, 5, 1);
        pc = 32'h3018;
        step("r34");
        n_hi = 0;
        for (int i = 0; i < 5; i++) begin
            step("r34");
            n_hi += int'(irq[0]);
        end
        chk("r34_len", 32'(n_hi), 32'd5);
        pc = PC_IDLE;
        step("r34");
        chk("r34_irq_off", 32'(irq[0]), 32'd0);
        chk("r34_spent", 32'(spent[0]), 32'd1);

        // Delayed pulse with rearm; held match fires only once.
        cfg_chan(1, 32'h3100, 3, 2, 3);
        pc = 32'h3100;
        n_hi = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            step("r35");
            if (irq[1] && first < 0) first = i;
            n_hi += int'(irq[1]);
        end
        chk("r35_first", 32'(first), 32'd4);
        chk("r35_len", 32'(n_hi), 32'd2);
        pc = PC_IDLE;
        step("r35");
        pc = 32'h3100;
        n_hi = 0;
        for (int i = 0; i < 10; i++) begin
            step("r35b");
            n_hi += int'(irq[1]);
        end
        chk("r35_second", 32'(n_hi), 32'd2);
        pc = PC_IDLE;

        // Sticky: held until ack, pulse ignored.
        cfg_chan(2, 32'h3200, 0, 1, 5);
        pc = 32'h3200;
        r = 0;
        while (!irq[2] && r < 10) begin
            step("r36");
            r++;
        end
        chk("r36_rise", 32'(irq[2]), 32'd1);
        n_hi = 1;
        for (int i = 0; i < 6; i++) begin
            step("r36");
            n_hi += int'(irq[2]);
        end
        chk("r36_len", 32'(n_hi), 32'd7);
        irq_ack[2] = 1'b1;
        step("r36");
        irq_ack[2] = 1'b0;
        chk("r36_fall", 32'(irq[2]), 32'd0);
        chk("r36_spent", 32'(spent[2]), 32'd1);
        pc = PC_IDLE;
        step("r36");

        // Two channels on one address fire together.
        cfg_chan(0, 32'h3000, 2, 3, 1);
        cfg_chan(3, 32'h3000, 2, 3, 1);
        pc = 32'h3000;
        step("r37");
        chk("r37_busy0", 32'(busy), 32'd1);
        for (int j = 1; j < 5; j++) begin
            step("r37");
            chk("r37_busy", 32'(busy), 32'd1);
            if (j == 3) chk("r37_sync", 32'({irq[3], irq[0]}), 32'd3);
        end
        pc = PC_IDLE;
        repeat (3) step("r37");

        // Disable during ASSERT beats a same-cycle ack.
        cfg_chan(4, 32'h3400, 0, 4, 1);
        pc = 32'h3400;
        step("r39");
        step("r39");
        chk("r39_hi", 32'(irq[4]), 32'd1);
        cfg_we = 1'b1; cfg_ch = 3'd4; cfg_field = 2'd3; cfg_wdata = 32'd0;
        irq_ack[4] = 1'b1;
        step("r39");
        cfg_we = 1'b0; irq_ack[4] = 1'b0;
        chk("r39_irq", 32'(irq[4]), 32'd0);
        chk("r39_spent", 32'(spent[4]), 32'd0);
        chk("r39_busy", 32'(busy), 32'd0);
        pc = PC_IDLE;
        step("r39");

        // Asynchronous reset in the middle of a delay.
        cfg_chan(5, 32'h3500, 10, 1, 1);
        pc = 32'h3500;
        repeat (4) step("r38");
        chk("r38_busy_pre", 32'(busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("r38_irq", 32'(irq), 32'd0);
        chk("r38_busy", 32'(busy), 32'd0);
        chk("r38_spent", 32'(spent), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_hi = 0;
        for (int i = 0; i < 15; i++) begin
            step("r38");
            n_hi += int'(irq[5]);
        end
        chk("r38_dead", 32'(n_hi), 32'd0);

        // Random traffic.
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++)
            cfg_chan(ch, 32'h3000 + 32'(4 * $urandom_range(0, 3)), $urandom_range(0, 4),
                     $urandom_range(0, 4), int'({$urandom_range(0, 3), 1'b1}));
        for (int i = 0; i < 1500; i++) begin
            int sel_pc;
            sel_pc = $urandom_range(0, 4);
            pc = (sel_pc == 4) ? PC_IDLE : 32'h3000 + 32'(4 * sel_pc);
            for (int ch = 0; ch < NUM_CH; ch++) irq_ack[ch] = ($urandom_range(0, 7) == 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_field = 2'($urandom_range(0, 3));
            case (cfg_field)
                2'd0: cfg_wdata = 32'h3000 + 32'(4 * $urandom_range(0, 3));
                2'd1, 2'd2: cfg_wdata = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 4));
                default: begin
                    cfg_wdata = 32'($urandom_range(0, 7));
                    if (int'(cfg_ch) < NUM_CH && m_active[int'(cfg_ch)]) cfg_wdata[0] = 1'b0;
                end
            endcase
            step("rnd");
        end
        cfg_we = 1'b0; irq_ack = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
